// File: rtl/log_softmax_ctrl.sv
// log_softmax_ctrl: buffers one frame, tracks its max, drives external exp/ln units, emits x - max - ln(sum exp(x - max)).
// Latency: NUM_DATA load cycles, NUM_DATA exp round trips, one ln round trip, then one output word per cycle.
// Backpressure: exp/ln requests and output words hold stable until their ready; input is refused outside LOAD.
module log_softmax_ctrl #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 10,
  localparam int ACC_W   = DATA_W + $clog2(NUM_DATA)
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  // frame input
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_mode_i,
  output logic              in_ready_o,
  // exp unit
  output logic              exp_req_valid_o,
  output logic [DATA_W-1:0] exp_req_data_o,
  input  logic              exp_req_ready_i,
  input  logic              exp_rsp_valid_i,
  input  logic [DATA_W-1:0] exp_rsp_data_i,
  // ln unit
  output logic              ln_req_valid_o,
  output logic [ACC_W-1:0]  ln_req_data_o,
  input  logic              ln_req_ready_i,
  input  logic              ln_rsp_valid_i,
  input  logic [DATA_W-1:0] ln_rsp_data_i,
  // result output
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              sat_o
);

  localparam int IDX_W = $clog2(NUM_DATA);
  localparam int CNT_W = $clog2(NUM_DATA + 1);
  localparam int SUB_W = DATA_W + 2;

  // Clamp bounds for the two-bit-extended difference arithmetic.
  localparam logic signed [SUB_W-1:0] SAT_HI = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUB_W-1:0] SAT_LO = {3'b111, {(DATA_W-1){1'b0}}};

  localparam logic [IDX_W-1:0] LAST_WR  = IDX_W'(NUM_DATA - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DATA - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DATA);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EXP  = 2'd1,
    S_LN   = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Clamp a wide difference into the DATA_W signed range.
  function automatic logic [DATA_W-1:0] f_sat(input logic signed [SUB_W-1:0] v);
    if (v > SAT_HI)
      return SAT_HI[DATA_W-1:0];
    else if (v < SAT_LO)
      return SAT_LO[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
  endfunction

  // True when f_sat would have to clamp this value.
  function automatic logic f_clamps(input logic signed [SUB_W-1:0] v);
    return (v > SAT_HI) || (v < SAT_LO);
  endfunction

  state_t            r_state;
  logic [DATA_W-1:0] r_buf [NUM_DATA];
  logic [IDX_W-1:0]  r_wr_idx;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_rsp_cnt;
  logic              r_mode;
  logic [DATA_W-1:0] r_max;
  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_lnsum;
  logic              r_sat;
  logic              r_in_rdy;
  logic              r_exp_vld;
  logic [DATA_W-1:0] r_exp_dat;
  logic              r_ln_vld;
  logic              r_ln_sent;
  logic [ACC_W-1:0]  r_ln_dat;
  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_dat;
  logic              r_out_last;

  logic                    w_in_fire;
  logic [DATA_W-1:0]       w_x;
  logic signed [SUB_W-1:0] w_x_ext;
  logic signed [SUB_W-1:0] w_max_ext;
  logic signed [SUB_W-1:0] w_ln_ext;
  logic signed [SUB_W-1:0] w_sub_max;
  logic signed [SUB_W-1:0] w_sub_ln;
  logic signed [SUB_W-1:0] w_out_raw;
  logic [ACC_W:0]          w_acc_sum;
  logic                    w_issue_ok;

  assign w_in_fire = in_valid_i && r_in_rdy;

  // The same read index walks the buffer during EXP issue and again during OUT.
  assign w_x       = r_buf[r_idx[IDX_W-1:0]];
  assign w_x_ext   = {{2{w_x[DATA_W-1]}}, w_x};
  assign w_max_ext = {{2{r_max[DATA_W-1]}}, r_max};
  assign w_ln_ext  = {{2{r_lnsum[DATA_W-1]}}, r_lnsum};
  assign w_sub_max = w_x_ext - w_max_ext;
  assign w_sub_ln  = w_sub_max - w_ln_ext;
  assign w_out_raw = r_mode ? w_sub_max : w_sub_ln;
  assign w_issue_ok = (r_idx < CNT_FULL);

  // One spare bit catches accumulator carry-out for saturation.
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, {(ACC_W-DATA_W){1'b0}}, exp_rsp_data_i};

  // Frame buffer: plain storage, no reset needed since every entry is written before it is read.
  always_ff @(posedge clock_i) begin
    if (w_in_fire)
      r_buf[r_wr_idx] <= in_data_i;
  end

  // Control FSM with all handshake outputs registered.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_LOAD;
      r_wr_idx   <= '0;
      r_idx      <= '0;
      r_rsp_cnt  <= '0;
      r_mode     <= 1'b0;
      r_max      <= '0;
      r_acc      <= '0;
      r_lnsum    <= '0;
      r_sat      <= 1'b0;
      r_in_rdy   <= 1'b0;
      r_exp_vld  <= 1'b0;
      r_exp_dat  <= '0;
      r_ln_vld   <= 1'b0;
      r_ln_sent  <= 1'b0;
      r_ln_dat   <= '0;
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_out_last <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_in_rdy <= 1'b1;
          if (w_in_fire) begin
            if (r_wr_idx == '0) begin
              // Word 0 opens the frame: sample mode, seed max, clear sticky state.
              r_mode <= in_mode_i;
              r_max  <= in_data_i;
              r_sat  <= 1'b0;
              r_acc  <= '0;
            end else if ($signed(in_data_i) > $signed(r_max)) begin
              r_max <= in_data_i;
            end
            if (r_wr_idx == LAST_WR) begin
              r_wr_idx  <= '0;
              r_in_rdy  <= 1'b0;
              r_idx     <= '0;
              r_rsp_cnt <= '0;
              r_state   <= r_mode ? S_OUT : S_EXP;
            end else begin
              r_wr_idx <= r_wr_idx + 1'b1;
            end
          end
        end

        S_EXP: begin
          // Issue requests in index order, refilling the output register on acceptance.
          if (w_issue_ok && (!r_exp_vld || exp_req_ready_i)) begin
            r_exp_vld <= 1'b1;
            r_exp_dat <= f_sat(w_sub_max);
            if (f_clamps(w_sub_max))
              r_sat <= 1'b1;
            r_idx <= r_idx + 1'b1;
          end else if (exp_req_ready_i) begin
            r_exp_vld <= 1'b0;
          end
          // Responses are in order and always accepted here.
          if (exp_rsp_valid_i) begin
            if (w_acc_sum[ACC_W]) begin
              r_acc <= '1;
              r_sat <= 1'b1;
            end else begin
              r_acc <= w_acc_sum[ACC_W-1:0];
            end
            if (r_rsp_cnt == CNT_LAST) begin
              r_rsp_cnt <= '0;
              r_exp_vld <= 1'b0;
              r_ln_sent <= 1'b0;
              r_state   <= S_LN;
            end else begin
              r_rsp_cnt <= r_rsp_cnt + 1'b1;
            end
          end
        end

        S_LN: begin
          // Exactly one request per frame; r_ln_sent prevents a second issue.
          if (!r_ln_sent) begin
            r_ln_vld  <= 1'b1;
            r_ln_dat  <= r_acc;
            r_ln_sent <= 1'b1;
          end else if (r_ln_vld && ln_req_ready_i) begin
            r_ln_vld <= 1'b0;
          end
          if (r_ln_sent && ln_rsp_valid_i) begin
            r_lnsum  <= ln_rsp_data_i;
            r_ln_vld <= 1'b0;
            r_idx    <= '0;
            r_state  <= S_OUT;
          end
        end

        S_OUT: begin
          if (r_out_vld && out_ready_i && r_out_last) begin
            // Last word taken: frame done, input reopens next cycle.
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_idx      <= '0;
            r_in_rdy   <= 1'b1;
            r_state    <= S_LOAD;
          end else if (w_issue_ok && (!r_out_vld || out_ready_i)) begin
            r_out_vld  <= 1'b1;
            r_out_dat  <= f_sat(w_out_raw);
            r_out_last <= (r_idx == CNT_LAST);
            if (f_clamps(w_out_raw))
              r_sat <= 1'b1;
            r_idx <= r_idx + 1'b1;
          end else if (out_ready_i) begin
            r_out_vld <= 1'b0;
          end
        end

        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign in_ready_o      = r_in_rdy;
  assign exp_req_valid_o = r_exp_vld;
  assign exp_req_data_o  = r_exp_dat;
  assign ln_req_valid_o  = r_ln_vld;
  assign ln_req_data_o   = r_ln_dat;
  assign out_valid_o     = r_out_vld;
  assign out_data_o      = r_out_dat;
  assign out_last_o      = r_out_last;
  assign sat_o           = r_sat;
  assign busy_o          = (r_state != S_LOAD) || (r_wr_idx != '0);

endmodule

// File: tb/tb_log_softmax_ctrl.sv
// tb_log_softmax_ctrl: scoreboard bench for log_softmax_ctrl at DATA_W=16, NUM_DATA=4.
// Latency: responses from the exp/ln models arrive one or more cycles after each accepted request.
// Backpressure: exp/ln/output readies are randomised when stalling is enabled for a frame.
module tb_log_softmax_ctrl;

  localparam int DW = 16;
  localparam int ND = 4;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid_i;
  logic [DW-1:0] in_data_i;
  logic          in_mode_i;
  logic          in_ready_o;
  logic          exp_req_valid_o;
  logic [DW-1:0] exp_req_data_o;
  logic          exp_req_ready_i;
  logic          exp_rsp_valid_i;
  logic [DW-1:0] exp_rsp_data_i;
  logic          ln_req_valid_o;
  logic [AW-1:0] ln_req_data_o;
  logic          ln_req_ready_i;
  logic          ln_rsp_valid_i;
  logic [DW-1:0] ln_rsp_data_i;
  logic          out_valid_o;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
  logic          out_ready_i;
  logic          busy_o;
  logic          sat_o;

  always #5 clk = ~clk;

  log_softmax_ctrl #(.DATA_W(DW), .NUM_DATA(ND)) dut (
    .clock_i         (clk),
    .reset_n_i       (rst_n),
    .in_valid_i      (in_valid_i),
    .in_data_i       (in_data_i),
    .in_mode_i       (in_mode_i),
    .in_ready_o      (in_ready_o),
    .exp_req_valid_o (exp_req_valid_o),
    .exp_req_data_o  (exp_req_data_o),
    .exp_req_ready_i (exp_req_ready_i),
    .exp_rsp_valid_i (exp_rsp_valid_i),
    .exp_rsp_data_i  (exp_rsp_data_i),
    .ln_req_valid_o  (ln_req_valid_o),
    .ln_req_data_o   (ln_req_data_o),
    .ln_req_ready_i  (ln_req_ready_i),
    .ln_rsp_valid_i  (ln_rsp_valid_i),
    .ln_rsp_data_i   (ln_rsp_data_i),
    .out_valid_o     (out_valid_o),
    .out_data_o      (out_data_o),
    .out_last_o      (out_last_o),
    .out_ready_i     (out_ready_i),
    .busy_o          (busy_o),
    .sat_o           (sat_o)
  );

  int     n_pass = 0;
  int     n_chk  = 0;
  longint exp_q[$];
  longint ln_q[$];
  longint out_d_q[$];
  bit     out_l_q[$];
  int     exp_val;
  int     ln_val;
  bit     stall_en = 1'b0;
  int     exp_pend = 0;
  bit     ln_pend  = 1'b0;
  int     exp_cnt  = 0;
  int     ln_cnt   = 0;
  bit     prev_stall = 1'b0;
  longint prev_dat;
  bit     prev_last;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  function automatic int clip16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic bit clamps16(input int v);
    return (v > 32767) || (v < -32768);
  endfunction

  // Reference model: pushes expected exp requests, ln request and outputs for one frame.
  task automatic expect_frame(input bit mode, input int x[ND], input int ev, input int lv, output bit esat);
    int mx;
    longint acc;
    mx = x[0];
    esat = 1'b0;
    for (int i = 1; i < ND; i++) if (x[i] > mx) mx = x[i];
    if (!mode) begin
      for (int i = 0; i < ND; i++) begin
        if (clamps16(x[i] - mx)) esat = 1'b1;
        exp_q.push_back(clip16(x[i] - mx));
      end
      acc = longint'(ev) * ND;
      if (acc > (longint'(1) << AW) - 1) begin
        acc = (longint'(1) << AW) - 1;
        esat = 1'b1;
      end
      ln_q.push_back(acc);
    end
    for (int i = 0; i < ND; i++) begin
      int v;
      v = mode ? (x[i] - mx) : (x[i] - mx - lv);
      if (clamps16(v)) esat = 1'b1;
      out_d_q.push_back(clip16(v));
      out_l_q.push_back(i == ND - 1);
    end
  endtask

  // Drive n words; called at a negedge, returns at a negedge. Mode toggles after word 0 on purpose.
  task automatic send_words(input bit mode, input int x[ND], input int n);
    for (int i = 0; i < n; i++) begin
      int to;
      in_valid_i = 1'b1;
      in_data_i  = x[i][DW-1:0];
      in_mode_i  = (i == 0) ? mode : ~mode;
      to = 0;
      while (!in_ready_o && to < 100) begin
        @(negedge clk);
        to++;
      end
      if (to >= 100) check_eq("in_ready_timeout", 0, 1);
      @(negedge clk);
      if (i == 0) begin
        check_eq("sat_clear_word0", sat_o, 0);
        check_eq("busy_partial", busy_o, 1);
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic run_frame(input bit mode, input int x[ND], input int ev, input int lv, input bit stall);
    bit esat;
    int to;
    stall_en = stall;
    exp_val  = ev;
    ln_val   = lv;
    exp_cnt  = 0;
    ln_cnt   = 0;
    expect_frame(mode, x, ev, lv, esat);
    send_words(mode, x, ND);
    to = 0;
    while ((out_d_q.size() != 0 || busy_o) && to < 3000) begin
      @(negedge clk);
      to++;
    end
    check_eq("frame_done_in_time", (to < 3000), 1);
    check_eq("exp_req_count", exp_cnt, mode ? 0 : ND);
    check_eq("ln_req_count", ln_cnt, mode ? 0 : 1);
    check_eq("sat_flag", sat_o, esat);
    check_eq("in_ready_after_frame", in_ready_o, 1);
    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("ln_q_drained", ln_q.size(), 0);
    stall_en = 1'b0;
  endtask

  // Environment: exp/ln response models, ready randomisation and output scoreboard, all at negedge.
  initial begin
    exp_req_ready_i = 1'b1;
    ln_req_ready_i  = 1'b1;
    out_ready_i     = 1'b1;
    exp_rsp_valid_i = 1'b0;
    exp_rsp_data_i  = '0;
    ln_rsp_valid_i  = 1'b0;
    ln_rsp_data_i   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_pend        = 0;
        ln_pend         = 1'b0;
        prev_stall      = 1'b0;
        exp_rsp_valid_i = 1'b0;
        ln_rsp_valid_i  = 1'b0;
      end else begin
        if (exp_pend > 0 && (!stall_en || $urandom_range(0, 2) != 0)) begin
          exp_rsp_valid_i = 1'b1;
          exp_rsp_data_i  = exp_val[DW-1:0];
          exp_pend--;
        end else begin
          exp_rsp_valid_i = 1'b0;
        end
        if (ln_pend) begin
          ln_rsp_valid_i = 1'b1;
          ln_rsp_data_i  = ln_val[DW-1:0];
          ln_pend        = 1'b0;
        end else begin
          ln_rsp_valid_i = 1'b0;
        end
        exp_req_ready_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        ln_req_ready_i  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready_i     = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;

        if (exp_req_valid_o && exp_req_ready_i) begin
          exp_cnt++;
          exp_pend++;
          if (exp_q.size() == 0) check_eq("exp_req_unexpected", 1, 0);
          else check_eq("exp_req_data", longint'($signed(exp_req_data_o)), exp_q.pop_front());
        end
        if (ln_req_valid_o && ln_req_ready_i) begin
          ln_cnt++;
          ln_pend = 1'b1;
          if (ln_q.size() == 0) check_eq("ln_req_unexpected", 1, 0);
          else check_eq("ln_req_data", longint'(ln_req_data_o), ln_q.pop_front());
        end
        if (prev_stall) begin
          check_eq("out_hold_valid", out_valid_o, 1);
          check_eq("out_hold_data", longint'($signed(out_data_o)), prev_dat);
          check_eq("out_hold_last", out_last_o, prev_last);
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_dat   = longint'($signed(out_data_o));
        prev_last  = out_last_o;
        if (out_valid_o && out_ready_i) begin
          if (out_d_q.size() == 0) check_eq("out_unexpected", 1, 0);
          else begin
            check_eq("out_data", longint'($signed(out_data_o)), out_d_q.pop_front());
            check_eq("out_last", out_last_o, out_l_q.pop_front());
          end
        end
      end
    end
  end

  // Main sequence.
  initial begin
    int f[ND];
    rst_n      = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    in_mode_i  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready_o, 0);
    check_eq("rst_exp_vld", exp_req_valid_o, 0);
    check_eq("rst_ln_vld", ln_req_valid_o, 0);
    check_eq("rst_out_vld", out_valid_o, 0);
    check_eq("rst_out_last", out_last_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_sat", sat_o, 0);
    check_eq("rst_out_data", out_data_o, 0);
    check_eq("rst_exp_data", exp_req_data_o, 0);
    check_eq("rst_ln_data", ln_req_data_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready_o, 1);
    check_eq("post_rst_busy", busy_o, 0);

    // Downscale only.
    f = '{5, 2, 7, -1};
    run_frame(1'b1, f, 0, 0, 1'b0);
    // Full log-softmax with fixed exp/ln model values.
    run_frame(1'b0, f, 100, 6, 1'b0);
    // Clamp on downscale; sat clears at next frame's word 0.
    f = '{32767, -32768, 0, 0};
    run_frame(1'b1, f, 0, 0, 1'b0);
    // Large exp results under random stalls on every handshake.
    f = '{5, 2, 7, -1};
    run_frame(1'b0, f, 65535, 6, 1'b1);
    run_frame(1'b0, f, 100, 6, 1'b1);
    // Random frames with stalls.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < ND; i++) f[i] = int'($urandom_range(0, 65535)) - 32768;
      run_frame(1'($urandom_range(0, 1)), f, int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 200)) - 100, 1'b1);
    end

    // Reset in the middle of a frame, then a clean frame.
    f = '{9, 1, 4, 3};
    send_words(1'b0, f, 2);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy_o, 0);
    check_eq("midrst_in_ready", in_ready_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy_after", busy_o, 0);
    check_eq("midrst_in_ready_after", in_ready_o, 1);
    f = '{-3, 8, 8, -20};
    run_frame(1'b0, f, 1000, 10, 1'b0);
    check_eq("final_out_q_empty", out_d_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/log_softmax_ctrl.md
LOG_SOFTMAX_CTRL -- requirements
Module: log_softmax_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: signed two's-complement data width.
REQ-002 SHALL have parameter NUM_DATA, default 10: words per frame, legal range 2..1024.
REQ-003 SHALL have derived localparam ACC_W = DATA_W + clog2(NUM_DATA): exp-sum accumulator width.
REQ-004 SHALL have ports clock_i in 1, the single clock; reset_n_i in 1, asynchronous active-low reset.
REQ-005 SHALL have ports in_valid_i in 1; in_data_i in DATA_W; in_mode_i in 1 (0 = log-softmax, 1 = downscale only); in_ready_o out 1.
REQ-006 SHALL have exp ports exp_req_valid_o out 1; exp_req_data_o out DATA_W; exp_req_ready_i in 1; exp_rsp_valid_i in 1; exp_rsp_data_i in DATA_W (unsigned).
REQ-007 SHALL have ln ports ln_req_valid_o out 1; ln_req_data_o out ACC_W (unsigned); ln_req_ready_i in 1; ln_rsp_valid_i in 1; ln_rsp_data_i in DATA_W (signed).
REQ-008 SHALL have outputs out_valid_o out 1; out_data_o out DATA_W; out_last_o out 1; out_ready_i in 1; busy_o out 1; sat_o out 1 (sticky saturation flag).

Function
REQ-009 SHALL implement FSM states LOAD, EXP, LN, OUT; reset state is LOAD.
REQ-010 In LOAD, in_ready_o SHALL be 1; a word is accepted on in_valid_i & in_ready_o, stored in an NUM_DATA-entry buffer at index 0..NUM_DATA-1.
REQ-011 in_mode_i SHALL be sampled with word 0 only and held for the frame.
REQ-012 A running signed maximum SHALL be kept; word 0 loads it unconditionally.
REQ-013 After word NUM_DATA-1 is accepted, the FSM SHALL go to EXP (mode 0) or OUT (mode 1) on the next cycle.
REQ-014 In EXP, requests SHALL be issued in index order with exp_req_data_o = sat(x_i - max); a request completes on exp_req_valid_o & exp_req_ready_i.
REQ-015 exp responses SHALL be treated as in order, at most one per cycle, and accepted unconditionally; each is added zero-extended into the accumulator, which is cleared at frame start.
REQ-016 Accumulator overflow SHALL saturate at 2^ACC_W-1 and set sat_o.
REQ-017 After the NUM_DATA-th response, the FSM SHALL go to LN; responses arriving outside EXP SHALL be ignored.
REQ-018 In LN, exactly one request SHALL be issued with ln_req_data_o = accumulator; ln_rsp_data_i is latched on ln_rsp_valid_i; the FSM then goes to OUT.
REQ-019 In OUT, word i SHALL be presented as out_data_o = sat(x_i - max - lnsum) for mode 0, or sat(x_i - max) for mode 1, with out_last_o = 1 only at i = NUM_DATA-1.
REQ-020 out_data_o and out_last_o SHALL hold stable while out_valid_o & ~out_ready_i, with one word per accepted cycle (full throughput).
REQ-021 After the last word is accepted, the FSM SHALL return to LOAD; in_ready_o SHALL rise on the following cycle.
REQ-022 Every subtraction SHALL be computed at DATA_W+2 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; any clamp SHALL set sat_o.
REQ-023 sat_o SHALL clear only at acceptance of word 0 of a new frame.
REQ-024 busy_o SHALL be 1 whenever the state is not LOAD, or the state is LOAD with a partial frame stored.

Reset
REQ-025 On reset_n_i low, the block SHALL immediately enter LOAD with word count, accumulator, max and lnsum at 0.
REQ-026 During reset, in_ready_o SHALL be 0; after reset it SHALL be 1.
REQ-027 During and after reset, all other outputs SHALL be 0: exp_req_valid_o, ln_req_valid_o, out_valid_o, out_last_o, busy_o, sat_o and the data outputs.
REQ-028 Reset asserted mid-frame SHALL discard the frame; no partial output SHALL follow.

Verification (DATA_W=16, NUM_DATA=4)
REQ-029 Mode 1, input 5, 2, 7, -1 -> output -2, -5, 0, -8 with last on the 4th word; no exp or ln requests; sat_o=0.
REQ-030 Mode 0, same input, exp model returns 100 per request and ln model returns 6 -> exp requests -2, -5, 0, -8; ln request 400; output -8, -11, -6, -14.
REQ-031 Mode 1, input 32767, -32768, 0, 0 -> second output clamps to -32768 and sat_o=1; sat_o clears on the next frame's word 0.
REQ-032 Mode 0, exp model returns 65535 four times -> ln request 262140 (ACC_W=18, no saturation); random exp_req_ready_i, ln_req_ready_i and out_ready_i stalls -> identical data, out_data_o stable while stalled.
REQ-033 Reset pulsed after 2 of 4 words, then a full new frame -> output reflects only the new frame; busy_o=0 immediately after reset.
